// File: rtl/alu_result_fifo_pkg.sv
// alu_res_pkg: shared unit-id constants and sizing helpers for alu_result_fifo.
// Entry layout, LSB first: data (WIDTH_OUT_DATA+1), src (2), then parity (1) when
// ALU_RES_PARITY_EN is defined.
package alu_res_pkg;
  localparam logic [1:0] SRC_ARITH = 2'd0;
  localparam logic [1:0] SRC_LOGIC = 2'd1;
  localparam logic [1:0] SRC_CMP   = 2'd2;
  localparam logic [1:0] SRC_SHIFT = 2'd3;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int entry_w(input int width_out_data);
`ifdef ALU_RES_PARITY_EN
    return width_out_data + 4;
`else
    return width_out_data + 3;
`endif
  endfunction
endpackage

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: ALU result capture / consumer drain bundle for alu_result_fifo.
// master: environment side (drives res_*, out_ready, clr_ovf).
// slave:  FIFO side (drives out_*, fifo_full, fifo_empty, overflow, drop_cnt).
// ALU_RES_PARITY_EN adds out_parity.
interface alu_result_fifo_if #(
  parameter int WIDTH_OUT_DATA = 16,
  parameter int DROP_CNT_WIDTH = 8
);
  logic [WIDTH_OUT_DATA:0] res_in;
  logic [WIDTH_OUT_DATA:0] out_data;
  logic [1:0] res_src;
  logic [1:0] out_src;
  logic res_valid;
  logic out_valid;
  logic out_ready;
  logic fifo_full;
  logic fifo_empty;
  logic overflow;
  logic clr_ovf;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
`ifdef ALU_RES_PARITY_EN
  logic out_parity;
`endif
  modport master (
    output res_in, res_valid, res_src, out_ready, clr_ovf,
`ifdef ALU_RES_PARITY_EN
    input out_parity,
`endif
    input out_data, out_src, out_valid, fifo_full, fifo_empty, overflow, drop_cnt
  );
  modport slave (
    input res_in, res_valid, res_src, out_ready, clr_ovf,
`ifdef ALU_RES_PARITY_EN
    output out_parity,
`endif
    output out_data, out_src, out_valid, fifo_full, fifo_empty, overflow, drop_cnt
  );
endinterface

// File: rtl/alu_result_fifo_mem.sv
// alu_res_fifo_mem: DEPTH x EW register array, one synchronous write port, async read.
// Ports: clk, we/wa/wd (write), ra/rd (read). No reset: contents are don't-care.
module alu_res_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int EW = 19
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [EW-1:0] wd,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [EW-1:0] rd
);
  logic [EW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers tagged ALU unit results and drains them over valid/ready.
// Ports: clk, rst (synchronous, active-low), bus (alu_result_fifo_if.slave).
// Optional: ALU_RES_PARITY_EN stores an even-parity bit per entry and drives out_parity.
module alu_result_fifo
  import alu_res_pkg::*;
#(
  parameter int WIDTH_OUT_DATA = 16,
  parameter int DEPTH = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  alu_result_fifo_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = entry_w(WIDTH_OUT_DATA);
  localparam int DW = WIDTH_OUT_DATA + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] wr_entry, rd_entry;
  logic full, empty, push, pop, drop, ovf;
  logic [DROP_CNT_WIDTH-1:0] cnt, cnt_base;
  always_comb begin
    full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    empty = wr_ptr == rd_ptr;
    pop = ~empty & bus.out_ready;
    push = bus.res_valid & (~full | pop);
    drop = bus.res_valid & full & ~pop;
    // clear applies first so a same-cycle drop still lands as a count of one
    cnt_base = bus.clr_ovf ? '0 : cnt;
  end
`ifdef ALU_RES_PARITY_EN
  assign wr_entry = {^bus.res_in, bus.res_src, bus.res_in};
  assign bus.out_parity = ~empty & rd_entry[DW+2];
`else
  assign wr_entry = {bus.res_src, bus.res_in};
`endif
  alu_res_fifo_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
    .clk(clk),
    .we(push),
    .wa(wr_ptr[AW-1:0]),
    .wd(wr_entry),
    .ra(rd_ptr[AW-1:0]),
    .rd(rd_entry)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      ovf <= drop | (ovf & ~bus.clr_ovf);
      cnt <= cnt_base + DROP_CNT_WIDTH'(drop & ~&cnt_base);
    end
  assign bus.out_valid = ~empty;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full = full;
  assign bus.overflow = ovf;
  assign bus.drop_cnt = cnt;
  assign bus.out_data = empty ? '0 : rd_entry[DW-1:0];
  assign bus.out_src = empty ? '0 : rd_entry[DW+1:DW];
endmodule
